// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the 5-stage RV32I core: datapath width, register
// index width, ALU operation and writeback-select encodings, plus a small
// helper used by the hazard logic.
// Optional feature macro used by the ID/EX stage: ID_EX_WB_BYPASS_EN.
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int ALU_OP_W  = 4;
  localparam int WB_SEL_W  = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2,
    WB_SEL_IMM = 2'd3
  } wb_sel_e;

  // True when an operand that is actually read names the given destination.
  // x0 is hard-wired zero, so a match on it never creates a dependency.
  function automatic logic reads_reg(input logic uses,
                                     input logic [REG_IDX_W-1:0] src,
                                     input logic [REG_IDX_W-1:0] dst);
    return uses && (dst != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector. Flags when the instruction in ID
// reads a register that the load currently in EX has not yet produced.
// Ports:
//   id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2 : decode-side operands
//   ex_valid, ex_mem_re, ex_rd                         : instruction in EX
//   hazard                                             : dependency detected
// ---------------------------------------------------------------------------
module load_use_detect
  import core_pkg::*;
(
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_valid,
  input  logic                 ex_mem_re,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 hazard
);

  logic w_dep_rs1;
  logic w_dep_rs2;

  assign w_dep_rs1 = reads_reg(id_uses_rs1, id_rs1, ex_rd);
  assign w_dep_rs2 = reads_reg(id_uses_rs2, id_rs2, ex_rd);
  assign hazard    = id_valid && ex_valid && ex_mem_re && (w_dep_rs1 || w_dep_rs2);

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_reg
// ID-to-EX pipeline register of the RV32I core. Captures decoded fields and
// register-file read data, inserts a bubble on a load-use hazard (asserting
// load_use_stall towards IF/ID), honours branch flush and downstream hold,
// and keeps a saturating count of hazard bubbles.
// Ports:
//   clk, rst_n         : clock (rising edge), async active-low reset
//   id_*               : decoded instruction from ID
//   flush              : kill the ID-to-EX transfer (loads a bubble)
//   ex_stall           : hold all EX registers
//   wb_regfile_we/rd/data : writeback port, used only with the bypass macro
//   ex_*               : registered EX copies
//   load_use_stall     : combinational stall request for PC and IF/ID
//   bubble_count       : saturating count of hazard bubbles
// Macro: ID_EX_WB_BYPASS_EN enables writeback-to-operand bypass on both the
// load path and the hold path.
// ---------------------------------------------------------------------------
module id_ex_pipeline_reg
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [ALU_OP_W-1:0]  id_alu_op,
  input  logic [WB_SEL_W-1:0]  id_wb_sel,
  input  logic                 id_regfile_we,
  input  logic                 id_mem_re,
  input  logic                 id_mem_we,
  input  logic                 flush,
  input  logic                 ex_stall,
  input  logic                 wb_regfile_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [ALU_OP_W-1:0]  ex_alu_op,
  output logic [WB_SEL_W-1:0]  ex_wb_sel,
  output logic                 ex_regfile_we,
  output logic                 ex_mem_re,
  output logic                 ex_mem_we,
  output logic                 load_use_stall,
  output logic [CNT_W-1:0]     bubble_count
);

  logic                 r_valid;
  logic [XLEN-1:0]      r_pc;
  logic [REG_IDX_W-1:0] r_rs1;
  logic [REG_IDX_W-1:0] r_rs2;
  logic [REG_IDX_W-1:0] r_rd;
  logic [XLEN-1:0]      r_rs1_data;
  logic [XLEN-1:0]      r_rs2_data;
  logic [XLEN-1:0]      r_imm;
  logic [ALU_OP_W-1:0]  r_alu_op;
  logic [WB_SEL_W-1:0]  r_wb_sel;
  logic                 r_regfile_we;
  logic                 r_mem_re;
  logic                 r_mem_we;
  logic [CNT_W-1:0]     r_bubble_count;

  logic                 w_hazard;
  logic [XLEN-1:0]      w_rs1_load;
  logic [XLEN-1:0]      w_rs2_load;
  logic [XLEN-1:0]      w_rs1_hold;
  logic [XLEN-1:0]      w_rs2_hold;

  load_use_detect u_load_use_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (r_valid),
    .ex_mem_re   (r_mem_re),
    .ex_rd       (r_rd),
    .hazard      (w_hazard)
  );

`ifdef ID_EX_WB_BYPASS_EN
  // A same-cycle writeback overrides the regfile read on capture, and also
  // refreshes a held operand so a long hold cannot keep a stale value once
  // the MEM/WB forwarding source has retired.
  logic w_wb_hit_id_rs1;
  logic w_wb_hit_id_rs2;
  logic w_wb_hit_ex_rs1;
  logic w_wb_hit_ex_rs2;

  assign w_wb_hit_id_rs1 = wb_regfile_we && (wb_rd != '0) && (wb_rd == id_rs1);
  assign w_wb_hit_id_rs2 = wb_regfile_we && (wb_rd != '0) && (wb_rd == id_rs2);
  assign w_wb_hit_ex_rs1 = wb_regfile_we && (wb_rd != '0) && (wb_rd == r_rs1);
  assign w_wb_hit_ex_rs2 = wb_regfile_we && (wb_rd != '0) && (wb_rd == r_rs2);

  assign w_rs1_load = w_wb_hit_id_rs1 ? wb_data : id_rs1_data;
  assign w_rs2_load = w_wb_hit_id_rs2 ? wb_data : id_rs2_data;
  assign w_rs1_hold = w_wb_hit_ex_rs1 ? wb_data : r_rs1_data;
  assign w_rs2_hold = w_wb_hit_ex_rs2 ? wb_data : r_rs2_data;
`else
  // Without the bypass the regfile is write-first, so the read data is
  // already current and the writeback port is not needed here.
  logic w_unused_wb;

  assign w_unused_wb = ^{wb_regfile_we, wb_rd, wb_data};
  assign w_rs1_load  = id_rs1_data;
  assign w_rs2_load  = id_rs2_data;
  assign w_rs1_hold  = r_rs1_data;
  assign w_rs2_hold  = r_rs2_data;
`endif

  // Stall request is suppressed when the bubble would be produced anyway
  // (flush) or when nothing moves this cycle (downstream hold).
  assign load_use_stall = w_hazard && !flush && !ex_stall;

  // Edge priority: flush, then hold, then hazard bubble, then normal load.
  // Bubbles clear only valid and the control bits; data fields are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid        <= 1'b0;
      r_pc           <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rd           <= '0;
      r_rs1_data     <= '0;
      r_rs2_data     <= '0;
      r_imm          <= '0;
      r_alu_op       <= '0;
      r_wb_sel       <= '0;
      r_regfile_we   <= 1'b0;
      r_mem_re       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_bubble_count <= '0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_regfile_we <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
    end else if (ex_stall) begin
      r_rs1_data <= w_rs1_hold;
      r_rs2_data <= w_rs2_hold;
    end else if (w_hazard) begin
      r_valid      <= 1'b0;
      r_regfile_we <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      if (r_bubble_count != '1) begin
        r_bubble_count <= r_bubble_count + CNT_W'(1);
      end
    end else begin
      r_valid      <= id_valid;
      r_pc         <= id_pc;
      r_rs1        <= id_rs1;
      r_rs2        <= id_rs2;
      r_rd         <= id_rd;
      r_rs1_data   <= w_rs1_load;
      r_rs2_data   <= w_rs2_load;
      r_imm        <= id_imm;
      r_alu_op     <= id_alu_op;
      r_wb_sel     <= id_wb_sel;
      r_regfile_we <= id_regfile_we && id_valid;
      r_mem_re     <= id_mem_re && id_valid;
      r_mem_we     <= id_mem_we && id_valid;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_rs1_data   = r_rs1_data;
  assign ex_rs2_data   = r_rs2_data;
  assign ex_imm        = r_imm;
  assign ex_alu_op     = r_alu_op;
  assign ex_wb_sel     = r_wb_sel;
  assign ex_regfile_we = r_regfile_we;
  assign ex_mem_re     = r_mem_re;
  assign ex_mem_we     = r_mem_we;
  assign bubble_count  = r_bubble_count;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipeline_reg
// Self-checking bench for id_ex_pipeline_reg (CNT_W = 4). Directed scenarios
// with literal expectations, then randomized traffic compared every cycle
// against a behavioural model of the stage.
// Honours ID_EX_WB_BYPASS_EN in its expectations.
// ---------------------------------------------------------------------------
module tb_id_ex_pipeline_reg;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rstN;
  logic        idValid;
  logic [31:0] idPc;
  logic [4:0]  idRs1, idRs2, idRd;
  logic        idUsesRs1, idUsesRs2;
  logic [31:0] idRs1Data, idRs2Data, idImm;
  logic [3:0]  idAluOp;
  logic [1:0]  idWbSel;
  logic        idRegWe, idMemRe, idMemWe;
  logic        flush, exStall;
  logic        wbWe;
  logic [4:0]  wbRd;
  logic [31:0] wbData;

  logic        exValid;
  logic [31:0] exPc;
  logic [4:0]  exRs1, exRs2, exRd;
  logic [31:0] exRs1Data, exRs2Data, exImm;
  logic [3:0]  exAluOp;
  logic [1:0]  exWbSel;
  logic        exRegWe, exMemRe, exMemWe;
  logic        loadUseStall;
  logic [CNT_W-1:0] bubbleCount;

  int checkCount = 0;
  int passCount  = 0;

  // Model of the architecturally visible EX contents.
  logic        mValid;
  logic [31:0] mPc, mRs1Data, mRs2Data, mImm;
  logic [4:0]  mRs1, mRs2, mRd;
  logic [3:0]  mAluOp;
  logic [1:0]  mWbSel;
  logic        mRegWe, mMemRe, mMemWe;
  int          mBubbles;

  id_ex_pipeline_reg #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rstN),
    .id_valid(idValid), .id_pc(idPc), .id_rs1(idRs1), .id_rs2(idRs2), .id_rd(idRd),
    .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2),
    .id_rs1_data(idRs1Data), .id_rs2_data(idRs2Data), .id_imm(idImm),
    .id_alu_op(idAluOp), .id_wb_sel(idWbSel),
    .id_regfile_we(idRegWe), .id_mem_re(idMemRe), .id_mem_we(idMemWe),
    .flush(flush), .ex_stall(exStall),
    .wb_regfile_we(wbWe), .wb_rd(wbRd), .wb_data(wbData),
    .ex_valid(exValid), .ex_pc(exPc), .ex_rs1(exRs1), .ex_rs2(exRs2), .ex_rd(exRd),
    .ex_rs1_data(exRs1Data), .ex_rs2_data(exRs2Data), .ex_imm(exImm),
    .ex_alu_op(exAluOp), .ex_wb_sel(exWbSel),
    .ex_regfile_we(exRegWe), .ex_mem_re(exMemRe), .ex_mem_we(exMemWe),
    .load_use_stall(loadUseStall), .bubble_count(bubbleCount)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
  endtask

  task automatic clearInputs();
    idValid = 0; idPc = 0; idRs1 = 0; idRs2 = 0; idRd = 0;
    idUsesRs1 = 0; idUsesRs2 = 0; idRs1Data = 0; idRs2Data = 0; idImm = 0;
    idAluOp = 0; idWbSel = 0; idRegWe = 0; idMemRe = 0; idMemWe = 0;
    flush = 0; exStall = 0; wbWe = 0; wbRd = 0; wbData = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveLoad(input logic [4:0] rd);
    clearInputs();
    idValid = 1; idPc = 32'h200; idRd = rd; idRegWe = 1; idMemRe = 1;
    idWbSel = 2'd1;
  endtask

  task automatic driveDependentAdd(input logic [4:0] src);
    clearInputs();
    idValid = 1; idPc = 32'h204; idRs1 = src; idRs2 = 5'd1; idRd = 5'd7;
    idUsesRs1 = 1; idUsesRs2 = 1; idRegWe = 1; idRs1Data = 32'h11; idRs2Data = 32'h22;
  endtask

  task automatic modelReset();
    mValid = 0; mPc = 0; mRs1 = 0; mRs2 = 0; mRd = 0; mRs1Data = 0; mRs2Data = 0;
    mImm = 0; mAluOp = 0; mWbSel = 0; mRegWe = 0; mMemRe = 0; mMemWe = 0;
    mBubbles = 0;
  endtask

  // ID depends on the load in EX when any register it reads (other than x0)
  // is the one the load will write.
  function automatic bit modelHazard();
    bit dep;
    dep = (idUsesRs1 && idRs1 == mRd) || (idUsesRs2 && idRs2 == mRd);
    return idValid && mValid && mMemRe && (mRd != 0) && dep;
  endfunction

  function automatic bit wbHits(input logic [4:0] r);
`ifdef ID_EX_WB_BYPASS_EN
    return wbWe && (wbRd != 0) && (wbRd == r);
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic modelStep();
    bit hz;
    hz = modelHazard();
    if (flush) begin
      mValid = 0; mRegWe = 0; mMemRe = 0; mMemWe = 0;
    end else if (exStall) begin
      if (wbHits(mRs1)) mRs1Data = wbData;
      if (wbHits(mRs2)) mRs2Data = wbData;
    end else if (hz) begin
      mValid = 0; mRegWe = 0; mMemRe = 0; mMemWe = 0;
      mBubbles = (mBubbles >= CNT_MAX) ? CNT_MAX : mBubbles + 1;
    end else begin
      mValid = idValid; mPc = idPc; mRs1 = idRs1; mRs2 = idRs2; mRd = idRd;
      mRs1Data = wbHits(idRs1) ? wbData : idRs1Data;
      mRs2Data = wbHits(idRs2) ? wbData : idRs2Data;
      mImm = idImm; mAluOp = idAluOp; mWbSel = idWbSel;
      mRegWe = idRegWe && idValid;
      mMemRe = idMemRe && idValid;
      mMemWe = idMemWe && idValid;
    end
  endtask

  // Random instruction mix biased towards register collisions and loads.
  task automatic applyStimulus();
    idValid   = ($urandom_range(7) != 0);
    idPc      = $urandom & 32'hFFFF_FFFC;
    idRs1     = 5'($urandom_range(3));
    idRs2     = 5'($urandom_range(3));
    idRd      = 5'($urandom_range(3));
    idUsesRs1 = 1'($urandom_range(1));
    idUsesRs2 = 1'($urandom_range(1));
    idRs1Data = $urandom;
    idRs2Data = $urandom;
    idImm     = $urandom;
    idAluOp   = 4'($urandom_range(10));
    idWbSel   = 2'($urandom_range(3));
    idRegWe   = 1'($urandom_range(1));
    idMemRe   = 1'($urandom_range(1));
    idMemWe   = ($urandom_range(5) == 0);
    flush     = ($urandom_range(7) == 0);
    exStall   = ($urandom_range(4) == 0);
    wbWe      = 1'($urandom_range(1));
    wbRd      = 5'($urandom_range(3));
    wbData    = $urandom;
  endtask

  task automatic checkOutput();
    cmp("ex_valid", 32'(exValid), 32'(mValid));
    cmp("ex_regfile_we", 32'(exRegWe), 32'(mRegWe));
    cmp("ex_mem_re", 32'(exMemRe), 32'(mMemRe));
    cmp("ex_mem_we", 32'(exMemWe), 32'(mMemWe));
    cmp("load_use_stall", 32'(loadUseStall), 32'(modelHazard() && !flush && !exStall));
    cmp("bubble_count", 32'(bubbleCount), 32'(mBubbles));
    if (mValid) begin
      cmp("ex_pc", exPc, mPc);
      cmp("ex_rs1", 32'(exRs1), 32'(mRs1));
      cmp("ex_rs2", 32'(exRs2), 32'(mRs2));
      cmp("ex_rd", 32'(exRd), 32'(mRd));
      cmp("ex_rs1_data", exRs1Data, mRs1Data);
      cmp("ex_rs2_data", exRs2Data, mRs2Data);
      cmp("ex_imm", exImm, mImm);
      cmp("ex_alu_op", 32'(exAluOp), 32'(mAluOp));
      cmp("ex_wb_sel", 32'(exWbSel), 32'(mWbSel));
    end
  endtask

  initial begin
    clearInputs();
    rstN = 0;
    #12 rstN = 1;
    #3;

    // Normal flow: one-cycle transfer.
    clearInputs();
    idValid = 1; idPc = 32'h100; idRd = 5'd5; idRegWe = 1;
    tick();
    cmp("normal ex_pc", exPc, 32'h100);
    cmp("normal ex_rd", 32'(exRd), 32'd5);
    cmp("normal ex_valid", 32'(exValid), 32'd1);
    cmp("normal ex_regfile_we", 32'(exRegWe), 32'd1);
    cmp("normal stall", 32'(loadUseStall), 32'd0);

    // Load-use: lw x6 then add x7,x6,x1.
    driveLoad(5'd6);
    tick();
    driveDependentAdd(5'd6);
    #1;
    cmp("loaduse stall", 32'(loadUseStall), 32'd1);
    tick();
    cmp("loaduse bubble valid", 32'(exValid), 32'd0);
    cmp("loaduse bubble we", 32'(exRegWe), 32'd0);
    cmp("loaduse bubble mem_re", 32'(exMemRe), 32'd0);
    cmp("loaduse bubble_count", 32'(bubbleCount), 32'd1);
    cmp("loaduse stall released", 32'(loadUseStall), 32'd0);
    tick();
    cmp("loaduse add ex_rd", 32'(exRd), 32'd7);
    cmp("loaduse add valid", 32'(exValid), 32'd1);

    // Load to x0 is never a hazard source.
    driveLoad(5'd0);
    tick();
    driveDependentAdd(5'd0);
    #1;
    cmp("x0 no stall", 32'(loadUseStall), 32'd0);
    tick();
    cmp("x0 bubble_count", 32'(bubbleCount), 32'd1);

    // Flush beats the hazard and does not count.
    driveLoad(5'd6);
    tick();
    driveDependentAdd(5'd6);
    flush = 1;
    #1;
    cmp("flush stall", 32'(loadUseStall), 32'd0);
    tick();
    cmp("flush valid", 32'(exValid), 32'd0);
    cmp("flush bubble_count", 32'(bubbleCount), 32'd1);

    // Downstream hold beats the hazard.
    driveLoad(5'd6);
    tick();
    driveDependentAdd(5'd6);
    exStall = 1;
    #1;
    cmp("hold stall", 32'(loadUseStall), 32'd0);
    tick();
    cmp("hold valid", 32'(exValid), 32'd1);
    cmp("hold ex_rd", 32'(exRd), 32'd6);
    cmp("hold ex_mem_re", 32'(exMemRe), 32'd1);
    exStall = 0;
    #1;
    cmp("hold released stall", 32'(loadUseStall), 32'd1);
    tick();
    cmp("hold released bubble_count", 32'(bubbleCount), 32'd2);

    // Writeback during a three-cycle hold.
    clearInputs();
    idValid = 1; idPc = 32'h300; idRs2 = 5'd9; idUsesRs2 = 1; idRs2Data = 32'h1234;
    tick();
    cmp("bypass pre ex_rs2_data", exRs2Data, 32'h1234);
    exStall = 1; wbWe = 1; wbRd = 5'd9; wbData = 32'hDEAD_BEEF;
    idRs2Data = 32'h5555;
    tick(); tick(); tick();
`ifdef ID_EX_WB_BYPASS_EN
    cmp("bypass hold ex_rs2_data", exRs2Data, 32'hDEAD_BEEF);
`else
    cmp("bypass hold ex_rs2_data", exRs2Data, 32'h1234);
`endif
    cmp("bypass hold ex_pc", exPc, 32'h300);

    // Asynchronous reset in the middle of a cycle.
    clearInputs();
    idValid = 1; idPc = 32'h400; idRd = 5'd3; idRegWe = 1; idRs1Data = 32'hABCD;
    tick();
    @(negedge clk);
    #2 rstN = 0;
    #1;
    cmp("reset ex_valid", 32'(exValid), 32'd0);
    cmp("reset ex_pc", exPc, 32'd0);
    cmp("reset ex_rd", 32'(exRd), 32'd0);
    cmp("reset ex_rs1_data", exRs1Data, 32'd0);
    cmp("reset ex_regfile_we", 32'(exRegWe), 32'd0);
    cmp("reset bubble_count", 32'(bubbleCount), 32'd0);
    @(negedge clk);
    rstN = 1;

    // Saturation: 17 hazards on a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      driveLoad(5'd6);
      tick();
      driveDependentAdd(5'd6);
      tick();
    end
    cmp("saturate bubble_count", 32'(bubbleCount), 32'd15);

    // Randomized traffic against the model.
    clearInputs();
    @(negedge clk);
    rstN = 0;
    #1;
    modelReset();
    @(negedge clk);
    rstN = 1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      applyStimulus();
      #1;
      checkOutput();
      modelStep();
    end
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
- Pipeline register between decode (ID) and execute (EX) in the 5-stage RV32I core.
- Captures decoded fields and register-file read data, and detects load-use hazards.
- On a load-use hazard it inserts a bubble and asserts a stall towards IF/ID.
- Handles branch flush and downstream hold; its ex_rs1/ex_rs2/ex_rd/ex_regfile_we outputs feed the forwarding unit and the ALU operand muxes.

Parameters:
XLEN, 32, datapath width
CNT_W, 16, width of bubble statistics counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
id_rs1_data, id_rs2_data  in  XLEN each  regfile read data
id_imm  in  XLEN  decoded immediate
id_alu_op  in  4  ALU operation
id_wb_sel  in  2  writeback source select
id_regfile_we, id_mem_re, id_mem_we  in  1 each  control bits
flush  in  1  branch/jump mispredict resolved in EX; kill ID-to-EX transfer
ex_stall  in  1  downstream (MEM busy) hold request
wb_regfile_we  in  1  writeback enable (bypass feature only)
wb_rd  in  5  writeback destination (bypass feature only)
wb_data  in  XLEN  writeback data (bypass feature only)
ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_alu_op, ex_wb_sel, ex_regfile_we, ex_mem_re, ex_mem_we  out  as inputs  registered EX copies
load_use_stall  out  1  hold PC and IF/ID this cycle (combinational)
bubble_count  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (rst_n low, async): all ex_* outputs 0, including ex_valid and all control bits; bubble_count 0.
- Hazard: hazard = id_valid & ex_valid & ex_mem_re & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- load_use_stall = hazard & ~flush & ~ex_stall. It is purely combinational, with no latency.
- Per-edge priority, highest first:
  1. flush: load a bubble. ex_valid, ex_regfile_we, ex_mem_re, ex_mem_we all 0; data fields don't-care (implementation keeps them). Flush beats ex_stall.
  2. ex_stall: hold all ex_* registers unchanged.
  3. hazard: load a bubble and increment bubble_count.
  4. otherwise: load all id_* fields. ex_valid = id_valid. Control bits are ANDed with id_valid, so an invalid instruction never writes.
- Latency: one cycle from ID to EX.
- A load-use stall lasts exactly one cycle: after the bubble, the load is in MEM and the forwarding unit takes over.
- A back-to-back load followed by a dependent load stalls once per dependency.
- x0 is never a hazard source.
- bubble_count saturates at all-ones and counts hazard bubbles only, not flushes.
- Reset asserted mid-stall clears everything immediately; load_use_stall follows via ex_valid = 0.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- Defined, load path: if wb_regfile_we & wb_rd != 0 & wb_rd == id_rs1, capture wb_data into ex_rs1_data; same for rs2. This covers a same-cycle regfile write/read.
- Defined, hold path: during ex_stall, if the write matches the held ex_rs1 or ex_rs2, refresh the corresponding ex_rs*_data with wb_data. Stale operands therefore cannot survive a multi-cycle hold after the MW forwarding source retires.
- Undefined: wb_* inputs are ignored, regfile data is captured verbatim, and the regfile must be write-first.

Decomposition:
- Shared package core_pkg holds:
  - XLEN
  - ALU_OP_W=4 and ALU op encodings
  - WB_SEL_W=2 and WB_SEL_ALU/MEM/PC4/IMM encodings
  - REG_IDX_W=5
- One sub-module, load_use_detect: combinational hazard equation, reusable by the IF/ID stall logic.

Test Plan:
- Reset: drive id_* nonzero, pulse rst_n low mid-cycle -> all ex_* 0 and bubble_count 0 asynchronously, before any clock edge.
- Normal flow: id_valid=1, pc=0x100, rd=5, regfile_we=1 -> next edge ex_pc=0x100, ex_rd=5, ex_valid=1, load_use_stall=0.
- Load-use: EX holds lw x6 (mem_re=1, rd=6), ID has add x7,x6,x1 (uses_rs1=1) -> load_use_stall=1 that cycle, next edge ex_valid=0 with controls 0, bubble_count=1, following edge the add enters EX. Repeat with rd=0 -> no stall.
- Priority: hazard present with flush=1 -> load_use_stall=0, bubble loaded, bubble_count unchanged. Hazard with ex_stall=1 -> EX registers held, load_use_stall=0.
- Saturation: CNT_W=4, force 17 hazards -> bubble_count stops at 15.
- Bypass (macro on): ex_stall held 3 cycles with ex_rs2=9, wb_regfile_we=1, wb_rd=9, wb_data=0xDEAD_BEEF -> ex_rs2_data=0xDEADBEEF. Macro off -> unchanged.
